core_exec_muldiv: RTL and testbench
===================================

# core_exec_muldiv

Parametrised, multi-cycle RV M-extension engine for the EXEC stage. It replaces the single-cycle combinational multiply and divide paths with an iterative shift-add multiplier and a restoring divider. Operand width and bits retired per cycle are configurable. It sits beside the ALU behind a valid/ready pair; the stage controller holds the instruction while `in_ready` is low.

## Interface
- `XLEN`, 32: operand/result width; must be even, ≥8.
- `MUL_BITS`, 1: multiplier bits consumed per cycle; must divide `XLEN` (1, 2, 4, 8).
- `DIV_BITS`, 1: quotient bits produced per cycle; must divide `XLEN` (1, 2, 4).

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `in_valid` in 1: request valid.
- `in_ready` out 1: high only in IDLE.
- `op` in 3: RV funct3 encoding. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `src_a` in XLEN: rs1 / dividend.
- `src_b` in XLEN: rs2 / divisor.
- `kill` in 1: trap/flush; abort any request.
- `out_valid` out 1: result valid, held until consumed.
- `out_ready` in 1: consumer accepts result.
- `result` out XLEN: registered result.
- `busy` out 1: state ≠ IDLE.

## Operation
- FSM states are IDLE, CALC, DONE. Reset puts the FSM in IDLE with `out_valid`=0, `result`=0, `busy`=0 and `in_ready`=1.
- Transitions, with `kill` checked first in every state:
  - Any state with `kill`=1: go to IDLE, clear `out_valid`, drop the request. A request presented alongside `kill` is not accepted.
  - IDLE with `in_valid`=1: latch `op` and the operand magnitudes, record the result sign, load the iteration counter with N, then go to CALC.
  - CALC: perform one step and decrement the counter. When the counter reaches 0, apply the sign fix-up, load `result`, set `out_valid` and go to DONE.
  - DONE with `out_ready`=1: go to IDLE. DONE with `out_ready`=0: hold `result` and `out_valid` stable.
- Iteration counts: multiply N = XLEN/MUL_BITS; divide N = XLEN/DIV_BITS.
- Multiply:
  - Magnitude shift-add into a 2·XLEN accumulator.
  - Signedness per operand: MUL and MULH treat a and b as signed; MULHSU treats a as signed and b as unsigned; MULHU treats both as unsigned.
  - If the operand signs differ, negate the full 2·XLEN product.
  - MUL returns product[XLEN-1:0]; the others return product[2·XLEN-1:XLEN].
- Divide:
  - Restoring division on magnitudes, DIV_BITS steps chained per cycle.
  - Quotient sign is sign(a)^sign(b); remainder sign is sign(a).
- Special cases are mandatory and bit-exact to the RV spec:
  - Divide by zero: quotient is all ones, remainder is `src_a`.
  - Signed overflow (−2^(XLEN−1) / −1): quotient is −2^(XLEN−1), remainder is 0.
- `result` changes only on the CALC→DONE edge and on reset.

## Timing
- Acceptance happens in cycle 0, the edge where IDLE and `in_valid`=1. `out_valid` is first high in cycle N+1.
- Default latencies (XLEN=32, 1 bit/cycle): multiply and divide both reach `out_valid` in cycle 33.
- If `out_ready` is already high when `out_valid` rises, the consume happens in cycle N+1 and `in_ready` returns in cycle N+2. Issue rate is one operation per N+2 cycles.
- `kill` takes effect on the next edge. `in_ready`=1 and `out_valid`=0 in the following cycle.
- Reset asserted mid-CALC or in DONE forces IDLE at the next edge, with outputs at their reset values.
- `in_ready` and `busy` are decoded from the state register only and do not depend combinationally on any input.

## Configuration
- `CORE_MULDIV_FAST_SPECIAL_EN` defined: IDLE detects the following at acceptance and goes straight to DONE, with `out_valid` in cycle 1:
  - divide by zero;
  - signed overflow;
  - multiply with an operand equal to 0.
- Undefined: every operation takes the full N iterations. Results must be identical either way; only latency differs.

## Test plan
- MUL/MULH/MULHU/MULHSU on 0xFFFFFFFF×0xFFFFFFFF → 0x00000001 / 0x00000000 / 0xFFFFFFFE / 0xFFFFFFFF. `out_valid` in cycle 33 at default parameters.
- MULH 0x80000000×0x80000000 → 0x40000000. MUL 7×(−3) → 0xFFFFFFEB.
- DIV 7/−2 → 0xFFFFFFFD. REM 7/−2 → 0x00000001. DIVU 100/7 → 14. REMU 100/7 → 2.
- Special cases:
  - DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0.
  - Latency is 1 cycle with the macro defined, 33 without.
- Backpressure: hold `out_ready`=0 for 10 cycles in DONE → `result` stable and `in_ready`=0 throughout. Then raise `out_ready` → `in_ready`=1 on the next cycle.
- Kill and reset:
  - `kill` at CALC cycle 12 → IDLE next cycle, no `out_valid`.
  - `kill` and `in_valid` together in IDLE → no acceptance.
  - `rst_n`=0 in DONE → `out_valid`=0 and `result`=0 the next cycle.
  - Repeat the multiply and divide checks with MUL_BITS=4, DIV_BITS=2 → multiply latency 9 cycles, divide 17.

Source files
------------

// File: rtl/core_exec_muldiv.sv
// core_exec_muldiv: iterative RV M-extension engine for the EXEC stage.
// Shift-add multiplier (MUL_BITS per cycle) and restoring divider
// (DIV_BITS per cycle) share one 2*XLEN accumulator. Requests arrive on a
// valid/ready pair; results are held in DONE until the consumer takes them.
// Optional feature macro: CORE_MULDIV_FAST_SPECIAL_EN -- when defined,
// divide-by-zero, signed overflow and multiply-by-zero finish directly from
// IDLE (result identical, only latency shortened).
module core_exec_muldiv #(
    parameter int XLEN     = 32,
    parameter int MUL_BITS = 1,
    parameter int DIV_BITS = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [CW-1:0] N_MUL = CW'(XLEN / MUL_BITS);
    localparam logic [CW-1:0] N_DIV = CW'(XLEN / DIV_BITS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_r, state_nxt_s;
    logic [2:0]          op_r;
    logic [2*XLEN-1:0]   acc_r, mcand_r;
    logic [XLEN-1:0]     opb_r, result_r;
    logic [CW-1:0]       cnt_r;
    logic                neg_r, rem_neg_r, div_zero_r, out_valid_r;

    logic                is_div_s, a_signed_s, b_signed_s, a_neg_s, b_neg_s;
    logic [XLEN-1:0]     mag_a_s, mag_b_s;
    logic                accept_s, fast_s, step_s, finish_s, drop_s;
    logic                special_s;
    logic [XLEN-1:0]     special_res_s, final_res_s;
    logic [2*XLEN-1:0]   acc_nxt_s, mcand_nxt_s, prod_s;
    logic [XLEN-1:0]     opb_nxt_s, quo_s, rem_fix_s, quo_fix_s;
    logic [XLEN:0]       rem_s;

    assign in_ready  = (state_r == ST_IDLE);
    assign busy      = (state_r != ST_IDLE);
    assign out_valid = out_valid_r;
    assign result    = result_r;

    // Decode operand signedness and form magnitudes of the incoming request.
    always_comb begin
        is_div_s = op[2];
        if (op[2]) begin
            a_signed_s = ~op[0];
            b_signed_s = ~op[0];
        end else begin
            a_signed_s = (op[1:0] != 2'b11);
            b_signed_s = ~op[1];
        end
        a_neg_s = a_signed_s & src_a[XLEN-1];
        b_neg_s = b_signed_s & src_b[XLEN-1];
        mag_a_s = a_neg_s ? ({XLEN{1'b0}} - src_a) : src_a;
        mag_b_s = b_neg_s ? ({XLEN{1'b0}} - src_b) : src_b;
    end

    // Detect operations that can complete straight from IDLE.
    always_comb begin
        special_s     = 1'b0;
        special_res_s = {XLEN{1'b0}};
`ifdef CORE_MULDIV_FAST_SPECIAL_EN
        if (is_div_s && (src_b == {XLEN{1'b0}})) begin
            special_s     = 1'b1;
            special_res_s = op[1] ? src_a : {XLEN{1'b1}};
        end else if (is_div_s && !op[0] && (src_a == {1'b1, {(XLEN-1){1'b0}}})
                     && (src_b == {XLEN{1'b1}})) begin
            special_s     = 1'b1;
            special_res_s = op[1] ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}};
        end else if (!is_div_s && ((src_a == {XLEN{1'b0}}) || (src_b == {XLEN{1'b0}}))) begin
            special_s     = 1'b1;
            special_res_s = {XLEN{1'b0}};
        end else begin
            special_s     = 1'b0;
        end
`else
        special_s     = 1'b0;
        special_res_s = {XLEN{1'b0}};
`endif
    end

    // One iteration: MUL_BITS shift-add steps or DIV_BITS restoring steps.
    always_comb begin
        acc_nxt_s   = acc_r;
        mcand_nxt_s = mcand_r;
        opb_nxt_s   = opb_r;
        rem_s       = {1'b0, acc_r[2*XLEN-1:XLEN]};
        quo_s       = acc_r[XLEN-1:0];
        if (op_r[2]) begin
            for (int j = 0; j < DIV_BITS; j++) begin
                rem_s = {rem_s[XLEN-1:0], quo_s[XLEN-1]};
                quo_s = {quo_s[XLEN-2:0], 1'b0};
                if (rem_s >= {1'b0, opb_r}) begin
                    rem_s    = rem_s - {1'b0, opb_r};
                    quo_s[0] = 1'b1;
                end else begin
                    quo_s[0] = 1'b0;
                end
            end
            acc_nxt_s = {rem_s[XLEN-1:0], quo_s};
        end else begin
            for (int j = 0; j < MUL_BITS; j++) begin
                if (opb_r[j]) begin
                    acc_nxt_s = acc_nxt_s + (mcand_r << j);
                end else begin
                    acc_nxt_s = acc_nxt_s;
                end
            end
            mcand_nxt_s = mcand_r << MUL_BITS;
            opb_nxt_s   = opb_r >> MUL_BITS;
        end
    end

    // Sign fix-up and result selection from the final iteration's value.
    always_comb begin
        prod_s    = neg_r ? ({(2*XLEN){1'b0}} - acc_nxt_s) : acc_nxt_s;
        quo_fix_s = div_zero_r ? {XLEN{1'b1}}
                  : (neg_r ? ({XLEN{1'b0}} - acc_nxt_s[XLEN-1:0]) : acc_nxt_s[XLEN-1:0]);
        rem_fix_s = rem_neg_r ? ({XLEN{1'b0}} - acc_nxt_s[2*XLEN-1:XLEN])
                              : acc_nxt_s[2*XLEN-1:XLEN];
        if (op_r[2]) begin
            final_res_s = op_r[1] ? rem_fix_s : quo_fix_s;
        end else if (op_r[1:0] == 2'b00) begin
            final_res_s = prod_s[XLEN-1:0];
        end else begin
            final_res_s = prod_s[2*XLEN-1:XLEN];
        end
    end

    // Next-state logic; kill overrides everything.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        fast_s      = 1'b0;
        step_s      = 1'b0;
        finish_s    = 1'b0;
        drop_s      = 1'b0;
        if (kill) begin
            state_nxt_s = ST_IDLE;
            drop_s      = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid && special_s) begin
                        state_nxt_s = ST_DONE;
                        fast_s      = 1'b1;
                    end else if (in_valid) begin
                        state_nxt_s = ST_CALC;
                        accept_s    = 1'b1;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_CALC: begin
                    step_s = 1'b1;
                    if (cnt_r == CW'(1)) begin
                        state_nxt_s = ST_DONE;
                        finish_s    = 1'b1;
                    end else begin
                        state_nxt_s = ST_CALC;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand latch, iteration datapath, result and valid registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_r        <= 3'b000;
            acc_r       <= {(2*XLEN){1'b0}};
            mcand_r     <= {(2*XLEN){1'b0}};
            opb_r       <= {XLEN{1'b0}};
            cnt_r       <= {CW{1'b0}};
            neg_r       <= 1'b0;
            rem_neg_r   <= 1'b0;
            div_zero_r  <= 1'b0;
            result_r    <= {XLEN{1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            if (accept_s) begin
                op_r       <= op;
                cnt_r      <= is_div_s ? N_DIV : N_MUL;
                opb_r      <= mag_b_s;
                mcand_r    <= {{XLEN{1'b0}}, mag_a_s};
                acc_r      <= is_div_s ? {{XLEN{1'b0}}, mag_a_s} : {(2*XLEN){1'b0}};
                neg_r      <= a_neg_s ^ b_neg_s;
                rem_neg_r  <= a_neg_s;
                div_zero_r <= (src_b == {XLEN{1'b0}});
            end else if (step_s) begin
                acc_r   <= acc_nxt_s;
                mcand_r <= mcand_nxt_s;
                opb_r   <= opb_nxt_s;
                cnt_r   <= cnt_r - CW'(1);
            end
            if (finish_s) begin
                result_r <= final_res_s;
            end else if (fast_s) begin
                result_r <= special_res_s;
            end
            if (drop_s) begin
                out_valid_r <= 1'b0;
            end else if (finish_s || fast_s) begin
                out_valid_r <= 1'b1;
            end else if ((state_r == ST_DONE) && out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_core_exec_muldiv.sv
// Directed testbench for core_exec_muldiv: default instance (1 bit/cycle)
// and a second instance with MUL_BITS=4, DIV_BITS=2.
module tb_core_exec_muldiv;

    localparam logic [2:0] OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010,
                           OP_MULHU = 3'b011, OP_DIV = 3'b100, OP_DIVU = 3'b101,
                           OP_REM = 3'b110, OP_REMU = 3'b111;
`ifdef CORE_MULDIV_FAST_SPECIAL_EN
    localparam int SP_LAT = 1;
`else
    localparam int SP_LAT = 33;
`endif

    logic        clk = 1'b0;
    logic        rst_n, in_valid, kill, out_ready, sel;
    logic [2:0]  op;
    logic [31:0] src_a, src_b;
    logic        in_valid0, in_valid1;
    logic        rdy0, ov0, busy0, rdy1, ov1, busy1;
    logic [31:0] res0, res1;
    logic        m_ready, m_valid, m_busy;
    logic [31:0] m_result;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    assign in_valid0 = in_valid & ~sel;
    assign in_valid1 = in_valid & sel;
    assign m_ready   = sel ? rdy1 : rdy0;
    assign m_valid   = sel ? ov1 : ov0;
    assign m_busy    = sel ? busy1 : busy0;
    assign m_result  = sel ? res1 : res0;

    core_exec_muldiv #(.XLEN(32), .MUL_BITS(1), .DIV_BITS(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(rdy0),
        .op(op), .src_a(src_a), .src_b(src_b), .kill(kill),
        .out_valid(ov0), .out_ready(out_ready), .result(res0), .busy(busy0)
    );

    core_exec_muldiv #(.XLEN(32), .MUL_BITS(4), .DIV_BITS(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(rdy1),
        .op(op), .src_a(src_a), .src_b(src_b), .kill(kill),
        .out_valid(ov1), .out_ready(out_ready), .result(res1), .busy(busy1)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request at cycle 0 and return the cycle in which out_valid rises.
    task automatic issue_and_wait(input logic [2:0] o, input logic [31:0] a,
                                  input logic [31:0] b, output int lat);
        op = o; src_a = a; src_b = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!m_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic s, input logic [2:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat);
        int lat;
        sel = s; out_ready = 1'b1;
        issue_and_wait(o, a, b, lat);
        check_val({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check_val(tag, m_result, exp);
        @(posedge clk); #1;
        check_val({tag, "_rdy"}, {31'd0, m_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        logic seen;
        rst_n = 1'b0; in_valid = 1'b0; kill = 1'b0; out_ready = 1'b1; sel = 1'b0;
        op = 3'b000; src_a = 32'd0; src_b = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_ov",   {31'd0, ov0},   32'd0);
        check_val("rst_res",  res0,           32'd0);
        check_val("rst_busy", {31'd0, busy0}, 32'd0);
        check_val("rst_rdy",  {31'd0, rdy0},  32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Default parameters: multiply
        run_op("mul_ff",    1'b0, OP_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33);
        run_op("mulh_ff",   1'b0, OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33);
        run_op("mulhu_ff",  1'b0, OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        run_op("mulhsu_ff", 1'b0, OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
        run_op("mulh_min",  1'b0, OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33);
        run_op("mul_7m3",   1'b0, OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
        // Default parameters: divide
        run_op("div_7m2",   1'b0, OP_DIV,    32'd7,   32'hFFFFFFFE, 32'hFFFFFFFD, 33);
        run_op("rem_7m2",   1'b0, OP_REM,    32'd7,   32'hFFFFFFFE, 32'h00000001, 33);
        run_op("divu_100",  1'b0, OP_DIVU,   32'd100, 32'd7,        32'd14,       33);
        run_op("remu_100",  1'b0, OP_REMU,   32'd100, 32'd7,        32'd2,        33);
        // Special cases
        run_op("div_by0",   1'b0, OP_DIV,    32'd5, 32'd0, 32'hFFFFFFFF, SP_LAT);
        run_op("rem_by0",   1'b0, OP_REM,    32'd5, 32'd0, 32'd5,        SP_LAT);
        run_op("remn_by0",  1'b0, OP_REM,    32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, SP_LAT);
        run_op("div_ovf",   1'b0, OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, SP_LAT);
        run_op("rem_ovf",   1'b0, OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, SP_LAT);

        // Backpressure: result and in_ready stable while out_ready is low
        sel = 1'b0; out_ready = 1'b0;
        issue_and_wait(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
        check_val("bp_lat", 32'(lat), 32'd33);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check_val("bp_res", m_result, 32'hFFFFFFFE);
            check_val("bp_rdy", {31'd0, m_ready}, 32'd0);
            check_val("bp_ov",  {31'd0, m_valid}, 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_val("bp_rel_rdy", {31'd0, m_ready}, 32'd1);
        check_val("bp_rel_ov",  {31'd0, m_valid}, 32'd0);

        // Kill in CALC cycle 12
        op = OP_DIVU; src_a = 32'd100; src_b = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        check_val("kill_busy_pre", {31'd0, m_busy}, 32'd1);
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check_val("kill_rdy",  {31'd0, m_ready}, 32'd1);
        check_val("kill_ov",   {31'd0, m_valid}, 32'd0);
        check_val("kill_busy", {31'd0, m_busy},  32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (m_valid) seen = 1'b1;
        end
        check_val("kill_no_ov", {31'd0, seen}, 32'd0);

        // Kill together with in_valid in IDLE: no acceptance
        op = OP_MUL; src_a = 32'd3; src_b = 32'd3; kill = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0; in_valid = 1'b0;
        check_val("kv_busy", {31'd0, m_busy},  32'd0);
        check_val("kv_rdy",  {31'd0, m_ready}, 32'd1);
        @(posedge clk); #1;
        check_val("kv_ov",   {31'd0, m_valid}, 32'd0);

        // Reset while in DONE
        out_ready = 1'b0;
        issue_and_wait(OP_MUL, 32'd7, 32'hFFFFFFFD, lat);
        check_val("rd_res_pre", m_result, 32'hFFFFFFEB);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_val("rd_ov",   {31'd0, m_valid}, 32'd0);
        check_val("rd_res",  m_result,          32'd0);
        check_val("rd_rdy",  {31'd0, m_ready},  32'd1);
        check_val("rd_busy", {31'd0, m_busy},   32'd0);
        rst_n = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;

        // Second instance: MUL_BITS=4, DIV_BITS=2
        run_op("p2_mul_ff",   1'b1, OP_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 9);
        run_op("p2_mulhu_ff", 1'b1, OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 9);
        run_op("p2_mulhsu",   1'b1, OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 9);
        run_op("p2_mulh_min", 1'b1, OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 9);
        run_op("p2_mul_7m3",  1'b1, OP_MUL,    32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 9);
        run_op("p2_div_7m2",  1'b1, OP_DIV,    32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 17);
        run_op("p2_rem_7m2",  1'b1, OP_REM,    32'd7, 32'hFFFFFFFE, 32'h00000001, 17);
        run_op("p2_divu_100", 1'b1, OP_DIVU,   32'd100, 32'd7, 32'd14, 17);
        run_op("p2_remu_100", 1'b1, OP_REMU,   32'd100, 32'd7, 32'd2,  17);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
